ps2_key_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_frame_rx.sv | 131 +++++++++++++
 rtl/ps2_key_rx.sv | 79 +++++++
 tb/tb_ps2_key_rx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, discard-code list and frame-receiver state type for the
// PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Keyboard housekeeping replies (BAT, ACK, errors) that never map to a key.
  localparam int         N_DISCARD = 6;
  localparam logic [7:0] DISCARD_CODES [N_DISCARD] =
    '{8'h00, 8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } rx_state_t;

  function automatic logic is_discard(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DISCARD; i++) begin
      if (code == DISCARD_CODES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line receiver: input synchronisers, clock glitch filter, 11-bit frame
// state machine with odd-parity/stop check and inter-edge timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4800
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int FCW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  logic           r_clk_s1, r_clk_s2;
  logic           r_dat_s1, r_dat_s2;
  logic           r_clk_filt;
  logic [FCW-1:0] r_fcnt;
  logic           w_fall;

  rx_state_t      r_state, w_state_nxt;
  logic [3:0]     r_bcnt;
  logic [TCW-1:0] r_tcnt;
  logic [7:0]     r_shift;
  logic           r_par;
  logic           r_stop;
  logic           w_frame_ok;

  // Stage: synchronise raw lines, then require FILTER agreeing samples
  // before the filtered clock follows the synchronised one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_fcnt     <= '0;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 != r_clk_filt) begin
        if (r_fcnt == FCW'(FILTER - 1)) begin
          r_clk_filt <= r_clk_s2;
          r_fcnt     <= '0;
        end else begin
          r_fcnt <= r_fcnt + FCW'(1);
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  // The sample event is the cycle in which the filter commits a 1->0 change.
  assign w_fall = r_clk_filt && !r_clk_s2 && (r_fcnt == FCW'(FILTER - 1));

  // Stage: frame state register and bit/timeout counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RECV) begin
        if (w_fall) begin
          r_bcnt <= r_bcnt + 4'd1;
          r_tcnt <= '0;
        end else begin
          r_tcnt <= r_tcnt + TCW'(1);
        end
      end else begin
        r_bcnt <= '0;
        r_tcnt <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == RECV && w_fall) begin
      if (r_bcnt < 4'd8) begin
        r_shift <= {r_dat_s2, r_shift[7:1]};
      end else if (r_bcnt == 4'd8) begin
        r_par <= r_dat_s2;
      end else begin
        r_stop <= r_dat_s2;
      end
    end
  end

  assign w_frame_ok = (^{r_shift, r_par}) && r_stop;

  always_comb begin
    w_state_nxt  = r_state;
    o_byte_valid = 1'b0;
    o_frame_err  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && !r_dat_s2) w_state_nxt = RECV;
      end
      RECV: begin
        if (w_fall) begin
          if (r_bcnt == 4'd9) w_state_nxt = CHECK;
        end else if (r_tcnt == TCW'(TIMEOUT)) begin
          o_frame_err = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      CHECK: begin
        o_byte_valid = w_frame_ok;
        o_frame_err  = !w_frame_ok;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_byte = r_shift;
  assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 set-2 scancode receiver producing the 11-bit ps2_key event word
// {toggle, pressed, ext, code}; handles E0/F0 prefixes and the E1 pause run.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4800
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        rx_busy
);

  logic        w_byte_valid;
  logic [7:0]  w_byte;
  logic        w_frame_err;
  logic        w_busy;

  logic [10:0] r_key;
  logic        r_ext;
  logic        r_rel;
  logic [2:0]  r_skip;

  ps2_frame_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_frame (
    .i_clk        (clk_sys),
    .i_rst_n      (RESET_N),
    .i_ps2_clk    (ps2_clk_in),
    .i_ps2_data   (ps2_data_in),
    .o_byte_valid (w_byte_valid),
    .o_byte       (w_byte),
    .o_frame_err  (w_frame_err),
    .o_busy       (w_busy)
  );

  // Stage: prefix/pause decode and event register; a broken frame voids
  // any prefix collected so far.
  always_ff @(posedge clk_sys) begin
    if (!RESET_N) begin
      r_key  <= '0;
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
    end else if (w_frame_err) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (w_byte_valid) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else if (w_byte == PS2_EXT) begin
        r_ext <= 1'b1;
      end else if (w_byte == PS2_REL) begin
        r_rel <= 1'b1;
      end else if (w_byte == PS2_PAUSE) begin
        r_skip <= PAUSE_SKIP;
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
      end else if (is_discard(w_byte)) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else begin
        r_key <= {~r_key[10], ~r_rel, r_ext, w_byte};
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign ps2_key   = r_key;
  assign frame_err = w_frame_err;
  assign rx_busy   = w_busy;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: bit-banged PS/2 frames, a key-event scoreboard fed
// when frames are driven, and timed sequences for latency/timeout/glitch/reset.
module tb_ps2_key_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 4800;
  localparam int HALF    = 20;
  localparam int GAP     = 30;

  logic        clk_sys     = 1'b0;
  logic        RESET_N     = 1'b0;
  logic        ps2_clk_in  = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        rx_busy;

  ps2_key_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_N     (RESET_N),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0]  code;
    logic        push;
    logic [10:0] key;
  } vec_t;

  vec_t        vecs[17];
  int          n_chk = 0;
  int          n_pass = 0;
  int          err_pulses = 0;
  logic        err_d = 1'b0;
  logic [10:0] prev_key = '0;
  logic [10:0] cur_key = '0;
  logic [10:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Scoreboard: every ps2_key change outside reset must match the next queued event.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!RESET_N) begin
        prev_key = ps2_key;
        err_d    = 1'b0;
      end else begin
        if (frame_err && !err_d) err_pulses++;
        err_d = frame_err;
        if (ps2_key !== prev_key) begin
          if (sb_q.size() == 0) chk("sb_unexpected_change", ps2_key, prev_key);
          else chk("sb_key", ps2_key, sb_q.pop_front());
          prev_key = ps2_key;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  // Drive one frame; optionally glitch the clock low after bit 4 and time
  // the stop-bit decode (CHECK after FILTER+2 cycles, key one cycle later).
  task automatic send_frame(input logic [7:0] code, input logic bad, input logic glitch,
                            input logic lat, input logic [10:0] exp_key);
    logic [10:0] bits;
    logic        par;
    par  = (~^code) ^ bad;
    bits = {1'b1, par, code, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data_in = bits[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      if (lat && i == 10) begin
        tick(FILTER + 2);
        chk("check_cycle_err", frame_err, bad);
        chk("check_cycle_busy", rx_busy, 1);
        chk("check_cycle_key_hold", ps2_key, cur_key);
        tick(1);
        chk("decode_latency_key", ps2_key, exp_key);
        chk("err_one_cycle", frame_err, 0);
        tick(HALF - FILTER - 3);
      end else begin
        tick(HALF);
      end
      ps2_clk_in = 1'b1;
      if (glitch && i == 4) begin
        tick(HALF);
        ps2_clk_in = 1'b0;
        tick(FILTER - 2);
        ps2_clk_in = 1'b1;
      end
    end
    tick(GAP);
  endtask

  task automatic frame_and_check(input string name, input logic [7:0] code, input logic bad,
                                 input logic glitch, input logic lat, input logic push,
                                 input logic [10:0] exp_key);
    int e0;
    e0 = err_pulses;
    if (push) sb_q.push_back(exp_key);
    send_frame(code, bad, glitch, lat, exp_key);
    chk({name, "_sb_drain"}, sb_q.size(), 0);
    chk({name, "_key"}, ps2_key, exp_key);
    chk({name, "_err_pulses"}, err_pulses - e0, bad);
    cur_key = exp_key;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      frame_and_check($sformatf("vec%0d", i), vecs[i].code, 1'b0, 1'b0, 1'b0,
                      vecs[i].push, vecs[i].key);
    end
  endtask

  initial begin
    int  cnt;
    int  e0;
    logic [10:0] bits;

    vecs[0]  = '{8'hE0, 1'b0, 11'h61C};
    vecs[1]  = '{8'hF0, 1'b0, 11'h61C};
    vecs[2]  = '{8'h75, 1'b1, 11'h175};
    vecs[3]  = '{8'hF0, 1'b0, 11'h175};
    vecs[4]  = '{8'h29, 1'b1, 11'h429};
    vecs[5]  = '{8'hE1, 1'b0, 11'h61C};
    vecs[6]  = '{8'h14, 1'b0, 11'h61C};
    vecs[7]  = '{8'h77, 1'b0, 11'h61C};
    vecs[8]  = '{8'hE1, 1'b0, 11'h61C};
    vecs[9]  = '{8'hF0, 1'b0, 11'h61C};
    vecs[10] = '{8'h14, 1'b0, 11'h61C};
    vecs[11] = '{8'hF0, 1'b0, 11'h61C};
    vecs[12] = '{8'h77, 1'b0, 11'h61C};
    vecs[13] = '{8'h76, 1'b1, 11'h276};
    vecs[14] = '{8'hE0, 1'b0, 11'h276};
    vecs[15] = '{8'hAA, 1'b0, 11'h276};
    vecs[16] = '{8'h16, 1'b1, 11'h616};

    RESET_N = 1'b0;
    tick(3);
    chk("reset_key", ps2_key, 0);
    chk("reset_err", frame_err, 0);
    chk("reset_busy", rx_busy, 0);
    RESET_N = 1'b1;
    tick(5);
    cur_key = '0;

    frame_and_check("make_1C", 8'h1C, 1'b0, 1'b0, 1'b1, 1'b1, 11'h61C);
    run_vecs(0, 2);
    frame_and_check("bad_parity_29", 8'h29, 1'b1, 1'b0, 1'b1, 1'b0, 11'h175);
    run_vecs(3, 4);

    // Start bit plus four data bits, then the clock stays high.
    e0   = err_pulses;
    bits = {3'b110, 8'h05, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ps2_data_in = bits[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      tick(HALF);
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = bits[4];
    tick(HALF);
    ps2_clk_in = 1'b0;
    cnt = 0;
    while (cnt < FILTER + TIMEOUT + 100) begin
      tick(1);
      cnt++;
      if (cnt == HALF) begin
        ps2_clk_in = 1'b1;
        chk("timeout_busy_partial", rx_busy, 1);
      end
      if (frame_err) break;
    end
    chk("timeout_cycles", cnt, FILTER + 2 + TIMEOUT);
    tick(1);
    chk("timeout_busy_after", rx_busy, 0);
    chk("timeout_err_one_cycle", frame_err, 0);
    chk("timeout_key_hold", ps2_key, cur_key);
    chk("timeout_err_pulses", err_pulses - e0, 1);
    tick(GAP);
    frame_and_check("after_timeout_05", 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 11'h205);

    frame_and_check("glitch_1B", 8'h1B, 1'b0, 1'b1, 1'b0, 1'b1, 11'h61B);

    bits = {3'b110, 8'h3A, 1'b0};
    for (int i = 0; i < 4; i++) begin
      ps2_data_in = bits[i];
      tick(HALF);
      ps2_clk_in = 1'b0;
      tick(HALF);
      ps2_clk_in = 1'b1;
    end
    chk("midframe_busy", rx_busy, 1);
    RESET_N = 1'b0;
    tick(2);
    chk("midreset_key", ps2_key, 0);
    chk("midreset_busy", rx_busy, 0);
    RESET_N = 1'b1;
    tick(GAP);
    cur_key = '0;
    frame_and_check("after_reset_1C", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 11'h61C);

    run_vecs(5, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
